// File: rtl/circle_draw_param.sv
// Parametrised Bresenham circle rasteriser: outline or filled disc, optional clear-screen pass.
// Pixel outputs are registered from next-cycle values, so they line up with the FSM state.
module circle_draw_param #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int COL_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [X_W-1:0]   centre_x,
  input  logic [Y_W-1:0]   centre_y,
  input  logic [R_W-1:0]   radius,
  input  logic [COL_W-1:0] colour,
  input  logic             fill,
  input  logic             clear,
  output logic             done,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [COL_W-1:0] vga_colour,
  output logic             vga_plot
);
  localparam int XY_W = (X_W > Y_W) ? X_W : Y_W;
  localparam int A_W  = ((XY_W > R_W) ? XY_W : R_W) + 2;
  localparam logic signed [A_W-1:0] ONE_A   = {{(A_W-1){1'b0}}, 1'b1};
  localparam logic signed [A_W-1:0] ZERO_A  = {A_W{1'b0}};
  localparam logic signed [A_W-1:0] SCR_W_A = A_W'(SCREEN_W);
  localparam logic signed [A_W-1:0] SCR_H_A = A_W'(SCREEN_H);
  localparam logic [X_W-1:0] CLR_X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] CLR_Y_LAST = Y_W'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_DRAW   = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state_r, state_n;
  logic armed_r;
  logic signed [A_W-1:0] cx_r, cx_n, cy_r, cy_n, ox_r, ox_n, oy_r, oy_n;
  logic signed [A_W-1:0] crit_r, crit_n, sx_r, sx_n;
  logic [COL_W-1:0] col_r, col_n;
  logic fill_r, fill_n;
  logic [2:0] phase_r, phase_n;
  logic [X_W-1:0] clr_x_r, clr_x_n;
  logic [Y_W-1:0] clr_y_r, clr_y_n;

  logic accept_s, span_end_s, draw_last_s, clr_last_s, more_s;
  logic signed [A_W-1:0] half_s, nxt_half_s, oy_upd_s, ox_upd_s, crit_upd_s;
  logic signed [A_W-1:0] cx_in_s, cy_in_s, rad_in_s, px_s, py_s;
  logic gen_s, on_s, done_s;
  logic [COL_W-1:0] pcol_s;

  assign cx_in_s  = $signed({{(A_W-X_W){1'b0}}, centre_x});
  assign cy_in_s  = $signed({{(A_W-Y_W){1'b0}}, centre_y});
  assign rad_in_s = $signed({{(A_W-R_W){1'b0}}, radius});

  // Loop-end decode and the Bresenham update step
  always_comb begin
    accept_s   = (state_r == S_IDLE) && start && armed_r;
    half_s     = phase_r[1] ? oy_r : ox_r;
    nxt_half_s = (phase_r[1:0] == 2'd0) ? ox_r : oy_r;
    span_end_s = (sx_r == (cx_r + half_s));
    clr_last_s = (clr_x_r == CLR_X_LAST) && (clr_y_r == CLR_Y_LAST);
    if (fill_r) begin
      draw_last_s = span_end_s && (phase_r[1:0] == 2'd3);
    end else begin
      draw_last_s = (phase_r == 3'd7);
    end
    oy_upd_s = oy_r + ONE_A;
    if (crit_r <= ZERO_A) begin
      ox_upd_s   = ox_r;
      crit_upd_s = crit_r + (oy_upd_s <<< 1) + ONE_A;
    end else begin
      ox_upd_s   = ox_r - ONE_A;
      crit_upd_s = crit_r + ((oy_upd_s - ox_upd_s) <<< 1) + ONE_A;
    end
    more_s = (oy_upd_s <= ox_upd_s);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE:   state_n = accept_s ? (clear ? S_CLEAR : S_DRAW) : S_IDLE;
      S_CLEAR:  state_n = clr_last_s ? S_DRAW : S_CLEAR;
      S_DRAW:   state_n = draw_last_s ? S_UPDATE : S_DRAW;
      S_UPDATE: state_n = more_s ? S_DRAW : S_DONE;
      S_DONE:   state_n = start ? S_DONE : S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Next values of latched request, Bresenham state and sweep counters
  always_comb begin
    cx_n = cx_r; cy_n = cy_r; col_n = col_r; fill_n = fill_r;
    ox_n = ox_r; oy_n = oy_r; crit_n = crit_r; sx_n = sx_r;
    phase_n = phase_r; clr_x_n = clr_x_r; clr_y_n = clr_y_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          cx_n = cx_in_s; cy_n = cy_in_s; col_n = colour; fill_n = fill;
          ox_n = rad_in_s; oy_n = ZERO_A; crit_n = ONE_A - rad_in_s;
          sx_n = cx_in_s - rad_in_s; phase_n = 3'd0;
          clr_x_n = {X_W{1'b0}}; clr_y_n = {Y_W{1'b0}};
        end else begin
          phase_n = phase_r;
        end
      end
      S_CLEAR: begin
        if (clr_y_r == CLR_Y_LAST) begin
          clr_y_n = {Y_W{1'b0}};
          clr_x_n = clr_x_r + {{(X_W-1){1'b0}}, 1'b1};
        end else begin
          clr_y_n = clr_y_r + {{(Y_W-1){1'b0}}, 1'b1};
        end
      end
      S_DRAW: begin
        if (!fill_r) begin
          phase_n = phase_r + 3'd1;
        end else if (span_end_s) begin
          phase_n = phase_r + 3'd1;
          sx_n    = cx_r - nxt_half_s;
        end else begin
          sx_n = sx_r + ONE_A;
        end
      end
      S_UPDATE: begin
        ox_n = ox_upd_s; oy_n = oy_upd_s; crit_n = crit_upd_s;
        sx_n = cx_r - ox_upd_s; phase_n = 3'd0;
      end
      default: phase_n = phase_r;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_r <= ZERO_A; cy_r <= ZERO_A; col_r <= {COL_W{1'b0}}; fill_r <= 1'b0;
      ox_r <= ZERO_A; oy_r <= ZERO_A; crit_r <= ZERO_A; sx_r <= ZERO_A;
      phase_r <= 3'd0; clr_x_r <= {X_W{1'b0}}; clr_y_r <= {Y_W{1'b0}};
    end else begin
      cx_r <= cx_n; cy_r <= cy_n; col_r <= col_n; fill_r <= fill_n;
      ox_r <= ox_n; oy_r <= oy_n; crit_r <= crit_n; sx_r <= sx_n;
      phase_r <= phase_n; clr_x_r <= clr_x_n; clr_y_r <= clr_y_n;
    end
  end

  // A request is accepted only after start has been seen low in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_r <= 1'b0;
    end else if (accept_s) begin
      armed_r <= 1'b0;
    end else if ((state_r == S_IDLE) && !start) begin
      armed_r <= 1'b1;
    end else begin
      armed_r <= armed_r;
    end
  end

  // Output decode from next-cycle state: point generation and clipping
  always_comb begin
    px_s = ZERO_A; py_s = ZERO_A; gen_s = 1'b0; pcol_s = col_n;
    case (state_n)
      S_CLEAR: begin
        px_s   = $signed({{(A_W-X_W){1'b0}}, clr_x_n});
        py_s   = $signed({{(A_W-Y_W){1'b0}}, clr_y_n});
        gen_s  = 1'b1;
        pcol_s = {COL_W{1'b0}};
      end
      S_DRAW: begin
        gen_s = 1'b1;
        if (fill_n) begin
          px_s = sx_n;
          case (phase_n[1:0])
            2'd0:    py_s = cy_n + oy_n;
            2'd1:    py_s = cy_n - oy_n;
            2'd2:    py_s = cy_n + ox_n;
            default: py_s = cy_n - ox_n;
          endcase
        end else begin
          case (phase_n)
            3'd0:    begin px_s = cx_n + ox_n; py_s = cy_n + oy_n; end
            3'd1:    begin px_s = cx_n + oy_n; py_s = cy_n + ox_n; end
            3'd2:    begin px_s = cx_n - ox_n; py_s = cy_n + oy_n; end
            3'd3:    begin px_s = cx_n - oy_n; py_s = cy_n + ox_n; end
            3'd4:    begin px_s = cx_n - ox_n; py_s = cy_n - oy_n; end
            3'd5:    begin px_s = cx_n - oy_n; py_s = cy_n - ox_n; end
            3'd6:    begin px_s = cx_n + ox_n; py_s = cy_n - oy_n; end
            default: begin px_s = cx_n + oy_n; py_s = cy_n - ox_n; end
          endcase
        end
      end
      default: gen_s = 1'b0;
    endcase
    on_s   = gen_s && !px_s[A_W-1] && (px_s < SCR_W_A) && !py_s[A_W-1] && (py_s < SCR_H_A);
    done_s = (state_n == S_DONE);
  end

  // Registered pixel and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0; vga_plot <= 1'b0;
      vga_x <= {X_W{1'b0}}; vga_y <= {Y_W{1'b0}}; vga_colour <= {COL_W{1'b0}};
    end else begin
      done       <= done_s;
      vga_plot   <= on_s;
      vga_x      <= on_s ? px_s[X_W-1:0] : {X_W{1'b0}};
      vga_y      <= on_s ? py_s[Y_W-1:0] : {Y_W{1'b0}};
      vga_colour <= on_s ? pcol_s : {COL_W{1'b0}};
    end
  end
endmodule

// File: tb/tb_circle_draw_param.sv
// Directed bench for circle_draw_param: vector table of requests with hand-computed
// plot/cycle counts, plus sequences for done handshake, pixel order and mid-draw reset.
module tb_circle_draw_param;
  localparam int W = 160;
  localparam int H = 120;

  logic       clk = 1'b0;
  logic       rst_n, start, fill, clear;
  logic [7:0] centre_x, radius, vga_x;
  logic [6:0] centre_y, vga_y;
  logic [2:0] colour, vga_colour;
  logic       done, vga_plot;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int cx; int cy; int r; int col; int fill; int clear; int exp_plots; int exp_cycles;
  } vec_t;
  vec_t vecs[12];

  int pix_x[$];
  int pix_y[$];
  int ol_x[$] = '{81, 80, 79, 80, 79, 80, 81, 80, 81, 81, 79, 79, 79, 79, 81, 81};
  int ol_y[$] = '{60, 61, 60, 61, 60, 59, 60, 59, 61, 61, 61, 61, 59, 59, 59, 59};
  int fl_x[$] = '{79, 80, 81, 79, 80, 81, 80, 80, 79, 80, 81, 79, 80, 81, 79, 80, 81, 79, 80, 81};
  int fl_y[$] = '{60, 60, 60, 60, 60, 60, 61, 59, 61, 61, 61, 59, 59, 59, 61, 61, 61, 59, 59, 59};
  int c8_x[$] = '{80, 80, 80, 80, 80, 80, 80, 80};
  int c8_y[$] = '{60, 60, 60, 60, 60, 60, 60, 60};

  circle_draw_param dut (
    .clk(clk), .rst_n(rst_n), .start(start), .centre_x(centre_x), .centre_y(centre_y),
    .radius(radius), .colour(colour), .fill(fill), .clear(clear), .done(done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_pix(input string name, input int ex[$], input int ey[$]);
    int bad = 0;
    if (pix_x.size() != ex.size()) bad = 1000 + pix_x.size();
    else for (int i = 0; i < ex.size(); i++) if (pix_x[i] != ex[i] || pix_y[i] != ey[i]) bad++;
    check(name, bad, 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cycles = 0, plots = 0, offscr = 0, colerr = 0, eqerr = 0, ordererr = 0;
    int held_bad = 0, ex = 0, ey = 0, dx, dy;
    bit seen = 1'b0;
    pix_x.delete(); pix_y.delete();
    centre_x = 8'(v.cx); centre_y = 7'(v.cy); radius = 8'(v.r); colour = 3'(v.col);
    fill = (v.fill != 0); clear = (v.clear != 0); start = 1'b1;
    while (!seen && cycles < 40000) begin
      @(negedge clk);
      cycles++;
      // latched request must ignore later input changes
      if (cycles == 2) begin
        centre_x = ~centre_x; centre_y = ~centre_y; radius = radius + 8'd3;
        colour = ~colour; fill = ~fill; clear = ~clear;
      end
      if (vga_plot) begin
        plots++;
        if (int'(vga_x) >= W || int'(vga_y) >= H) offscr++;
        if (v.clear != 0 && plots <= W * H) begin
          if (int'(vga_x) != ex || int'(vga_y) != ey || vga_colour != 3'd0) ordererr++;
          ey++;
          if (ey == H) begin ey = 0; ex++; end
        end else begin
          if (int'(vga_colour) != v.col) colerr++;
          dx = int'(vga_x) - v.cx;
          dy = int'(vga_y) - v.cy;
          if (dx * dx + dy * dy > v.r * v.r + v.r) eqerr++;
          pix_x.push_back(int'(vga_x));
          pix_y.push_back(int'(vga_y));
        end
      end
      if (done) seen = 1'b1;
    end
    check($sformatf("v%0d_done_seen", idx), int'(seen), 1);
    if (v.exp_cycles >= 0) check($sformatf("v%0d_cycles", idx), cycles, v.exp_cycles);
    if (v.exp_plots >= 0) check($sformatf("v%0d_plots", idx), plots, v.exp_plots);
    else check($sformatf("v%0d_some_plots", idx), int'(plots > 0), 1);
    check($sformatf("v%0d_offscreen", idx), offscr, 0);
    check($sformatf("v%0d_colour", idx), colerr, 0);
    check($sformatf("v%0d_radius_bound", idx), eqerr, 0);
    if (v.clear != 0) check($sformatf("v%0d_clear_order", idx), ordererr, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!done || vga_plot) held_bad++;
    end
    check($sformatf("v%0d_done_held", idx), held_bad, 0);
    start = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_done_drop", idx), int'(done), 0);
    @(negedge clk);
  endtask

  initial begin
    int first, dcnt, bad;
    vecs[0]  = '{80, 60, 0, 1, 0, 0, 8, 10};
    vecs[1]  = '{80, 60, 1, 2, 0, 0, 16, 19};
    vecs[2]  = '{80, 60, 2, 3, 0, 0, 16, 19};
    vecs[3]  = '{80, 60, 3, 4, 0, 0, 24, 28};
    vecs[4]  = '{80, 60, 10, 6, 0, 0, 64, 73};
    vecs[5]  = '{0, 0, 10, 7, 0, 0, 18, 73};
    vecs[6]  = '{80, 60, 0, 1, 1, 0, 4, 6};
    vecs[7]  = '{80, 60, 1, 2, 1, 0, 20, 23};
    vecs[8]  = '{80, 60, 2, 3, 1, 0, 28, 31};
    vecs[9]  = '{159, 119, 1, 5, 0, 0, 6, 19};
    vecs[10] = '{80, 60, 0, 5, 0, 1, 19208, 19210};
    vecs[11] = '{200, 125, 80, 6, 1, 0, -1, -1};

    rst_n = 1'b0; start = 1'b0; fill = 1'b0; clear = 1'b0;
    centre_x = 8'd0; centre_y = 7'd0; radius = 8'd0; colour = 3'd0;
    repeat (2) @(negedge clk);
    check("reset_done", int'(done), 0);
    check("reset_plot", int'(vga_plot), 0);
    check("reset_xy", int'(vga_x) + int'(vga_y), 0);
    check("reset_colour", int'(vga_colour), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_vec(i, vecs[i]);
      if (i == 1) check_pix("outline_r1_order", ol_x, ol_y);
      if (i == 7) check_pix("fill_r1_order", fl_x, fl_y);
      if (i == 10) check_pix("clear_then_centre", c8_x, c8_y);
    end

    // start dropped mid-draw: done must be a single-cycle pulse
    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd1; colour = 3'd1;
    fill = 1'b0; clear = 1'b0; start = 1'b1;
    first = 0; dcnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done) begin
        dcnt++;
        if (first == 0) first = c;
      end
    end
    check("pulse_first_cycle", first, 19);
    check("pulse_width", dcnt, 1);

    // asynchronous reset in the middle of a draw
    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd10; start = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_reset_x", int'(vga_x), 70);
    rst_n = 1'b0;
    #1;
    check("midreset_plot", int'(vga_plot), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_xyc", int'(vga_x) + int'(vga_y) + int'(vga_colour), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (vga_plot || done) bad++;
    end
    check("no_plot_without_new_start", bad, 0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    run_vec(12, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
